// File: rtl/elevator_request_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : elevator_request_queue_if
// Description : Signal bundle between the call-button front end, the request
//               queue and the elevator state machine.
//               call_btn        - raw call buttons, bit i = floor i
//               current_floor   - floor reported back by the state machine
//               requested_floor - target floor fed to the state machine
//               pending         - pending-request mask
//               door_open       - high while the door dwells open
//               dir_up          - SCAN direction, 1 = up
//               Modport slave is the request queue; master is its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface elevator_request_queue_if;
    logic [15:0] call_btn;
    logic [3:0]  current_floor;
    logic [3:0]  requested_floor;
    logic [15:0] pending;
    logic        door_open;
    logic        dir_up;

    modport slave (
        input  call_btn,
        input  current_floor,
        output requested_floor,
        output pending,
        output door_open,
        output dir_up
    );

    modport master (
        output call_btn,
        output current_floor,
        input  requested_floor,
        input  pending,
        input  door_open,
        input  dir_up
    );
endinterface
`default_nettype wire

// File: rtl/elevator_request_queue.sv
`default_nettype none
// ============================================================================
// Module      : elevator_request_queue
// Description : Captures call-button presses into a pending mask, picks the
//               next target floor with a SCAN policy and holds the door open
//               for a dwell period on arrival.
// Ports       : clk    - system clock
//               reset  - asynchronous reset, active-high
//               bus    - elevator_request_queue_if.slave (call_btn,
//                        current_floor in; requested_floor, pending,
//                        door_open, dir_up out, all registered)
// Options     : ELEVATOR_DEBOUNCE_EN - adds a 2-flop synchronizer and a
//               per-button debounce counter ahead of edge detection.
// Revision    : 1.0 - initial release
// ============================================================================
module elevator_request_queue #(
    parameter int          NUM_FLOORS      = 10,
    parameter logic [31:0] DWELL_CYCLES    = 32'd20000000,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic                          clk,
    input  logic                          reset,
    elevator_request_queue_if.slave       bus
);

    localparam logic [15:0] c_FLOOR_MASK = 16'((17'd1 << NUM_FLOORS) - 17'd1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVICE = 2'd1,
        ST_DWELL   = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_pending;
    logic [15:0] r_btn_prev;
    logic [3:0]  r_req;
    logic        r_door;
    logic        r_dir_up;
    logic [31:0] r_dwell;

    logic [15:0] w_btn_level;

    // ------------------------------------------------------------------
    // Button conditioning
    // ------------------------------------------------------------------
`ifdef ELEVATOR_DEBOUNCE_EN
    logic [15:0] r_sync1;
    logic [15:0] r_sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.call_btn;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar gi = 0; gi < 16; gi++) begin : g_debounce
        logic [15:0] r_cnt;
        logic        r_level;

        // The level flips only after DEBOUNCE_CYCLES consecutive cycles of
        // disagreement; any return to the old level restarts the count.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_cnt   <= '0;
                r_level <= 1'b0;
            end else if (r_sync2[gi] == r_level) begin
                r_cnt   <= '0;
            end else if (r_cnt == DEBOUNCE_CYCLES - 16'd1) begin
                r_cnt   <= '0;
                r_level <= r_sync2[gi];
            end else begin
                r_cnt   <= r_cnt + 16'd1;
            end
        end

        assign w_btn_level[gi] = r_level;
    end
`else
    assign w_btn_level = bus.call_btn;
`endif

    // ------------------------------------------------------------------
    // Edge detect and pending update
    // ------------------------------------------------------------------
    logic [15:0] w_rise;
    logic [15:0] w_cur_onehot;
    logic [15:0] w_clear;
    logic [15:0] w_set;
    logic [15:0] w_pending_next;
    logic        w_arrive;
    logic        w_cur_press;

    assign w_rise       = w_btn_level & ~r_btn_prev & c_FLOOR_MASK;
    assign w_cur_onehot = 16'd1 << bus.current_floor;
    assign w_cur_press  = |(w_rise & w_cur_onehot);
    assign w_arrive     = (r_state == ST_SERVICE) && (bus.current_floor == r_req)
                          && r_pending[r_req];
    assign w_clear      = w_arrive ? (16'd1 << r_req) : 16'd0;
    // A press of the floor being cleared is absorbed by the arrival; a press
    // of the current floor during dwell only extends the dwell.
    assign w_set        = w_rise & ~w_clear
                          & ~((r_state == ST_DWELL) ? w_cur_onehot : 16'd0);
    assign w_pending_next = ((r_pending & ~w_clear) | w_set) & c_FLOOR_MASK;

    // ------------------------------------------------------------------
    // SCAN target selection
    // ------------------------------------------------------------------
    logic       w_lo_ge_found, w_lo_gt_found, w_hi_le_found, w_hi_lt_found;
    logic [3:0] w_lo_ge, w_lo_gt, w_hi_le, w_hi_lt;
    logic [3:0] w_sel_target;
    logic       w_sel_reverse;
    logic       w_sel_valid;

    always_comb begin
        w_lo_ge_found = 1'b0; w_lo_ge = 4'd0;
        w_lo_gt_found = 1'b0; w_lo_gt = 4'd0;
        w_hi_le_found = 1'b0; w_hi_le = 4'd0;
        w_hi_lt_found = 1'b0; w_hi_lt = 4'd0;
        // Descending scan leaves the lowest match; ascending the highest.
        for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
            if (r_pending[f] && (4'(f) >= bus.current_floor)) begin
                w_lo_ge_found = 1'b1; w_lo_ge = 4'(f);
            end
            if (r_pending[f] && (4'(f) > bus.current_floor)) begin
                w_lo_gt_found = 1'b1; w_lo_gt = 4'(f);
            end
        end
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (r_pending[f] && (4'(f) <= bus.current_floor)) begin
                w_hi_le_found = 1'b1; w_hi_le = 4'(f);
            end
            if (r_pending[f] && (4'(f) < bus.current_floor)) begin
                w_hi_lt_found = 1'b1; w_hi_lt = 4'(f);
            end
        end
    end

    assign w_sel_valid   = |r_pending;
    assign w_sel_target  = r_dir_up ? (w_lo_ge_found ? w_lo_ge : w_hi_lt)
                                    : (w_hi_le_found ? w_hi_le : w_lo_gt);
    assign w_sel_reverse = w_sel_valid && (r_dir_up ? !w_lo_ge_found : !w_hi_le_found);

    // ------------------------------------------------------------------
    // Request FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_pending  <= '0;
            r_btn_prev <= '0;
            r_req      <= 4'd0;
            r_door     <= 1'b0;
            r_dir_up   <= 1'b1;
            r_dwell    <= '0;
        end else begin
            r_btn_prev <= w_btn_level;
            r_pending  <= w_pending_next;
            case (r_state)
                ST_IDLE: begin
                    r_req <= bus.current_floor;
                    if (w_sel_valid) begin
                        r_state <= ST_SERVICE;
                        r_req   <= w_sel_target;
                        if (w_sel_reverse) r_dir_up <= ~r_dir_up;
                    end
                end
                ST_SERVICE: begin
                    if (w_arrive) begin
                        r_door  <= 1'b1;
                        r_dwell <= DWELL_CYCLES - 32'd1;
                        r_state <= ST_DWELL;
                    end else if (!w_sel_valid) begin
                        r_state <= ST_IDLE;
                        r_req   <= bus.current_floor;
                    end else begin
                        r_req <= w_sel_target;
                        if (w_sel_reverse) r_dir_up <= ~r_dir_up;
                    end
                end
                ST_DWELL: begin
                    r_req <= bus.current_floor;
                    if (w_cur_press) begin
                        r_dwell <= DWELL_CYCLES - 32'd1;
                    end else if (r_dwell == 32'd0) begin
                        r_door <= 1'b0;
                        if (w_sel_valid) begin
                            r_state <= ST_SERVICE;
                            r_req   <= w_sel_target;
                            if (w_sel_reverse) r_dir_up <= ~r_dir_up;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_dwell <= r_dwell - 32'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.requested_floor = r_req;
    assign bus.pending         = r_pending;
    assign bus.door_open       = r_door;
    assign bus.dir_up          = r_dir_up;

endmodule
`default_nettype wire

// File: tb/tb_elevator_request_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_elevator_request_queue
// Description : Directed self-checking bench for elevator_request_queue with
//               NUM_FLOORS=10 and DWELL_CYCLES=8. The bench plays the
//               elevator state machine by driving current_floor directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_elevator_request_queue;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   n_door;

    elevator_request_queue_if bus();

    elevator_request_queue #(
        .NUM_FLOORS      (10),
        .DWELL_CYCLES    (32'd8),
        .DEBOUNCE_CYCLES (16'd4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [15:0] btns);
        bus.call_btn = btns;
        tick(1);
        bus.call_btn = 16'd0;
    endtask

    // Called right after the arrival edge; counts cycles the door stays open
    // (bounded so a stuck door still ends the run).
    task automatic count_door(output int n);
        n = bus.door_open ? 1 : 0;
        while (bus.door_open && n < 40) begin
            tick(1);
            if (bus.door_open) n++;
        end
    endtask

    initial begin
        n_checks          = 0;
        n_fail            = 0;
        reset             = 1'b1;
        bus.call_btn      = 16'd0;
        bus.current_floor = 4'd0;
        tick(2);
        check("rst_pending", 32'(bus.pending), 32'h0);
        check("rst_req", 32'(bus.requested_floor), 32'd0);
        check("rst_door", 32'(bus.door_open), 32'd0);
        check("rst_dir", 32'(bus.dir_up), 32'd1);
        reset = 1'b0;
        tick(1);

        // Single call to floor 5 from floor 0
        pulse(16'h0020);
        check("single_pending", 32'(bus.pending), 32'h020);
        check("single_req_1cyc", 32'(bus.requested_floor), 32'd0);
        tick(1);
        check("single_req_2cyc", 32'(bus.requested_floor), 32'd5);
        bus.current_floor = 4'd5;
        tick(1);
        check("single_arr_pending", 32'(bus.pending), 32'h0);
        check("single_arr_door", 32'(bus.door_open), 32'd1);
        count_door(n_door);
        check("single_dwell_len", 32'(n_door), 32'd8);
        tick(1);
        check("single_idle_req", 32'(bus.requested_floor), 32'd5);
        check("single_dir", 32'(bus.dir_up), 32'd1);

        // SCAN preempt: heading 2 -> 7, floor 4 requested on the way
        bus.current_floor = 4'd2;
        tick(1);
        pulse(16'h0080);
        tick(1);
        check("preempt_req7", 32'(bus.requested_floor), 32'd7);
        pulse(16'h0010);
        check("preempt_pending", 32'(bus.pending), 32'h090);
        tick(1);
        check("preempt_req4", 32'(bus.requested_floor), 32'd4);
        bus.current_floor = 4'd4;
        tick(1);
        check("preempt_arr4_pending", 32'(bus.pending), 32'h080);
        count_door(n_door);
        check("preempt_dwell_len", 32'(n_door), 32'd8);
        check("preempt_next_req", 32'(bus.requested_floor), 32'd7);
        check("preempt_dir", 32'(bus.dir_up), 32'd1);
        bus.current_floor = 4'd7;
        tick(1);
        check("preempt_arr7_door", 32'(bus.door_open), 32'd1);
        count_door(n_door);
        check("preempt_final_pending", 32'(bus.pending), 32'h0);

        // Reversal: at 6 going up, requests at 1 and 3 only
        bus.current_floor = 4'd6;
        tick(1);
        pulse(16'h000A);
        check("rev_pending", 32'(bus.pending), 32'h00A);
        tick(1);
        check("rev_req3", 32'(bus.requested_floor), 32'd3);
        check("rev_dir", 32'(bus.dir_up), 32'd0);
        bus.current_floor = 4'd3;
        tick(1);
        check("rev_arr3_pending", 32'(bus.pending), 32'h002);
        count_door(n_door);
        check("rev_req1", 32'(bus.requested_floor), 32'd1);
        check("rev_dir_hold", 32'(bus.dir_up), 32'd0);
        bus.current_floor = 4'd1;
        tick(1);
        count_door(n_door);
        check("rev_done_pending", 32'(bus.pending), 32'h0);

        // Dwell extend: zero-travel call at floor 3, re-press at count 2
        bus.current_floor = 4'd3;
        tick(1);
        pulse(16'h0008);
        check("ext_pending_set", 32'(bus.pending), 32'h008);
        tick(1);
        check("ext_req", 32'(bus.requested_floor), 32'd3);
        tick(1);
        check("ext_arr_door", 32'(bus.door_open), 32'd1);
        check("ext_arr_pending", 32'(bus.pending), 32'h0);
        tick(5);
        pulse(16'h0008);
        check("ext_press_pending", 32'(bus.pending), 32'h0);
        count_door(n_door);
        check("ext_dwell_len", 32'(n_door), 32'd8);

        // Held button yields one request; invalid floor ignored
        bus.call_btn = 16'h0004;
        tick(10);
        check("held_pending", 32'(bus.pending), 32'h004);
        check("held_req", 32'(bus.requested_floor), 32'd2);
        bus.current_floor = 4'd2;
        tick(1);
        check("held_arr_door", 32'(bus.door_open), 32'd1);
        tick(89);
        check("held_no_repeat", 32'(bus.pending), 32'h0);
        check("held_door_closed", 32'(bus.door_open), 32'd0);
        bus.call_btn = 16'd0;
        tick(1);
        pulse(16'h1000);
        tick(1);
        check("invalid_pending", 32'(bus.pending), 32'h0);
        check("invalid_req", 32'(bus.requested_floor), 32'd2);

        // Reset mid-dwell with requests 2 and 5 outstanding
        bus.current_floor = 4'd3;
        tick(1);
        pulse(16'h0008);
        tick(2);
        pulse(16'h0024);
        check("mid_door", 32'(bus.door_open), 32'd1);
        check("mid_pending", 32'(bus.pending), 32'h024);
        check("mid_dir", 32'(bus.dir_up), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check("arst_pending", 32'(bus.pending), 32'h0);
        check("arst_door", 32'(bus.door_open), 32'd0);
        check("arst_req", 32'(bus.requested_floor), 32'd0);
        check("arst_dir", 32'(bus.dir_up), 32'd1);
        tick(2);
        reset = 1'b0;
        tick(2);
        check("post_rst_pending", 32'(bus.pending), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
